// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrub controller for ECC-protected memory words.
// Walks the array one word per interval. Each word is read with its error
// flag, and a word that flags an error gets its voted value written back,
// which restores the redundant copies. The scrubber uses the memory port
// only in cycles where cpu_busy is low.
// Optional macro SCRUB_ERR_LOG_EN adds the last_err_addr and err_sticky
// outputs, which record the most recent corrected address.
module ecc_scrubber #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int INTERVAL = 1024,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cpu_busy,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              scrub_active,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]  err_count,
    output logic              pass_done
`ifdef SCRUB_ERR_LOG_EN
    ,
    output logic [ADDR_W-1:0] last_err_addr,
    output logic              err_sticky
`endif
);

    localparam int TMR_W = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        NEXT
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   interval_cnt;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  capture;
    logic               start_scrub;

    // A scrub starts once the interval has fully elapsed while idle.
    assign start_scrub  = (state == IDLE) && enable && (interval_cnt == TMR_MAX);

    // The CPU always wins the port, so ownership drops the moment it is busy.
    assign scrub_active = ((state == READ) || (state == WRITE)) && !cpu_busy;
    assign mem_we       = (state == WRITE) && !cpu_busy;
    assign mem_addr     = addr;
    assign mem_wdata    = capture;

    // Interval timer: held at zero while disabled, restarted when a scrub begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interval_cnt <= '0;
        end else if (!enable) begin
            interval_cnt <= '0;
        end else if (start_scrub) begin
            interval_cnt <= '0;
        end else if (interval_cnt != TMR_MAX) begin
            interval_cnt <= interval_cnt + 1'b1;
        end
    end

    // Scrub sequencer: request, read, optional writeback, then advance the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            capture   <= '0;
            err_count <= '0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_scrub) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!cpu_busy) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (cpu_busy) begin
                        state <= REQ;
                    end else begin
                        capture <= mem_rdata;
                        if (mem_err) begin
                            state <= WRITE;
                        end else begin
                            state     <= NEXT;
                            pass_done <= (addr == LAST_ADDR);
                        end
                    end
                end
                WRITE: begin
                    if (cpu_busy) begin
                        state <= REQ;
                    end else begin
                        if (err_count != CNT_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        state     <= NEXT;
                        pass_done <= (addr == LAST_ADDR);
                    end
                end
                NEXT: begin
                    addr  <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCRUB_ERR_LOG_EN
    // Error log: remembers where the most recent successful correction happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_err_addr <= '0;
            err_sticky    <= 1'b0;
        end else if (mem_we) begin
            last_err_addr <= addr;
            err_sticky    <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ecc_scrubber.sv
// tb_ecc_scrubber: directed bench for ecc_scrubber on a 4-word array with a
// 4-cycle interval and a 2-bit error counter. A small memory model supplies
// data and error flags; a scrub model predicts outputs every cycle.
module tb_ecc_scrubber;

    localparam int DATA_W   = 20;
    localparam int ADDR_W   = 2;
    localparam int DEPTH    = 4;
    localparam int INTERVAL = 4;
    localparam int CNT_W    = 2;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    // Model activity labels.
    localparam int M_WAIT  = 0;
    localparam int M_ASK   = 1;
    localparam int M_FETCH = 2;
    localparam int M_FIX   = 3;
    localparam int M_STEP  = 4;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              cpu_busy;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;
    logic              scrub_active;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [CNT_W-1:0]  err_count;
    logic              pass_done;
`ifdef SCRUB_ERR_LOG_EN
    logic [ADDR_W-1:0] last_err_addr;
    logic              err_sticky;
`endif

    int checks;
    int failures;

    // Memory array contents and per-word error flags.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              bad [DEPTH];

    // Write and read logs.
    int write_cnt [DEPTH];
    int total_writes;
    int last_w_addr;
    logic [DATA_W-1:0] last_w_data;
    int reads [$];

    // Scrub model state.
    int m_ph;
    int m_tmr;
    int m_addr;
    logic [DATA_W-1:0] m_cap;
    int m_cnt;
    int m_last;
    logic m_sticky;

    ecc_scrubber #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .INTERVAL(INTERVAL),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cpu_busy     (cpu_busy),
        .mem_rdata    (mem_rdata),
        .mem_err      (mem_err),
        .scrub_active (scrub_active),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .err_count    (err_count),
        .pass_done    (pass_done)
`ifdef SCRUB_ERR_LOG_EN
        ,
        .last_err_addr(last_err_addr),
        .err_sticky   (err_sticky)
`endif
    );

    assign mem_rdata = mem[mem_addr];
    assign mem_err   = bad[mem_addr];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic busy);
        @(posedge clk);
        #2;
        enable   = en;
        cpu_busy = busy;
    endtask

    task automatic clearLogs();
        for (int i = 0; i < DEPTH; i++) write_cnt[i] = 0;
        total_writes = 0;
        reads.delete();
    endtask

    task automatic waitPass(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #3;
            n++;
            if (pass_done) break;
        end
        if (n >= budget && !pass_done) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout actual=no_pass expected=pass_done within %0d cycles", name, budget);
        end
    endtask

    task automatic waitModel(input string name, input int ph, input int addr, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #2;
            n++;
            if (m_ph == ph && (addr < 0 || m_addr == addr)) break;
        end
        if (!(m_ph == ph && (addr < 0 || m_addr == addr))) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout actual=phase%0d expected=phase%0d", name, m_ph, ph);
        end
    endtask

    // Memory writes land when the scrubber drives a writeback; also log reads.
    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            bad[mem_addr] = 1'b0;
            write_cnt[mem_addr] = write_cnt[mem_addr] + 1;
            total_writes = total_writes + 1;
            last_w_addr = int'(mem_addr);
            last_w_data = mem_wdata;
        end else if (scrub_active) begin
            reads.push_back(int'(mem_addr));
        end
    end

    // Scrub model: what the controller must be doing each cycle.
    always @(posedge clk or posedge rst) begin
        int nph;
        if (rst) begin
            m_ph = M_WAIT; m_tmr = 0; m_addr = 0; m_cap = '0;
            m_cnt = 0; m_last = 0; m_sticky = 1'b0;
        end else begin
            nph = m_ph;
            if (m_ph == M_WAIT) begin
                if (enable && m_tmr == INTERVAL - 1) nph = M_ASK;
            end else if (m_ph == M_ASK) begin
                if (!enable) nph = M_WAIT;
                else if (!cpu_busy) nph = M_FETCH;
            end else if (m_ph == M_FETCH) begin
                if (cpu_busy) nph = M_ASK;
                else begin
                    m_cap = mem[m_addr];
                    nph = bad[m_addr] ? M_FIX : M_STEP;
                end
            end else if (m_ph == M_FIX) begin
                if (cpu_busy) nph = M_ASK;
                else begin
                    m_cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
                    m_last = m_addr;
                    m_sticky = 1'b1;
                    nph = M_STEP;
                end
            end else begin
                m_addr = (m_addr + 1) % DEPTH;
                nph = M_WAIT;
            end
            if (!enable) m_tmr = 0;
            else if (m_ph == M_WAIT && nph == M_ASK) m_tmr = 0;
            else if (m_tmr < INTERVAL - 1) m_tmr = m_tmr + 1;
            m_ph = nph;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic exp_we;
        exp_we = (m_ph == M_FIX) && !cpu_busy;
        checkOutput("cyc_scrub_active", 32'(scrub_active),
                    32'(((m_ph == M_FETCH) || (m_ph == M_FIX)) && !cpu_busy));
        checkOutput("cyc_mem_we", 32'(mem_we), 32'(exp_we));
        checkOutput("cyc_mem_addr", 32'(mem_addr), 32'(m_addr));
        checkOutput("cyc_err_count", 32'(err_count), 32'(m_cnt));
        checkOutput("cyc_pass_done", 32'(pass_done), 32'((m_ph == M_STEP) && (m_addr == DEPTH - 1)));
        if (exp_we) checkOutput("cyc_mem_wdata", 32'(mem_wdata), 32'(m_cap));
`ifdef SCRUB_ERR_LOG_EN
        checkOutput("cyc_last_err_addr", 32'(last_err_addr), 32'(m_last));
        checkOutput("cyc_err_sticky", 32'(err_sticky), 32'(m_sticky));
`endif
    end

    initial begin
        int n;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        enable = 1'b0;
        cpu_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DATA_W'(32'h111 * (i + 1));
            bad[i] = 1'b0;
        end
        clearLogs();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);

        // Clean pass: four reads, no writes.
        $display("[TB] clean pass");
        clearLogs();
        applyStimulus(1'b1, 1'b0);
        waitPass("clean_pass", 200);
        checkOutput("clean_read_count", 32'(reads.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < reads.size()) checkOutput("clean_read_addr", 32'(reads[i]), 32'(i));
        end
        checkOutput("clean_no_writes", 32'(total_writes), 32'd0);
        checkOutput("clean_err_count", 32'(err_count), 32'd0);

        // Single correction at address 2.
        $display("[TB] single correction");
        clearLogs();
        mem[2] = 20'h5A5A5;
        bad[2] = 1'b1;
        waitPass("single_pass", 200);
        checkOutput("single_writes", 32'(total_writes), 32'd1);
        checkOutput("single_w_addr", 32'(last_w_addr), 32'd2);
        checkOutput("single_w_data", 32'(last_w_data), 32'h5A5A5);
        checkOutput("single_err_count", 32'(err_count), 32'd1);
        checkOutput("single_flag_cleared", 32'(bad[2]), 32'd0);
`ifdef SCRUB_ERR_LOG_EN
        checkOutput("single_last_err_addr", 32'(last_err_addr), 32'd2);
        checkOutput("single_err_sticky", 32'(err_sticky), 32'd1);
`endif

        // CPU contention during READ and WRITE at address 1.
        $display("[TB] cpu contention");
        clearLogs();
        mem[1] = 20'h12345;
        bad[1] = 1'b1;
        waitModel("contend_read", M_FETCH, 1, 100);
        cpu_busy = 1'b1;
        #1;
        checkOutput("contend_read_active", 32'(scrub_active), 32'd0);
        checkOutput("contend_read_we", 32'(mem_we), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("contend_back_to_req", 32'(m_ph), 32'(M_ASK));
        checkOutput("contend_same_addr", 32'(mem_addr), 32'd1);
        waitModel("contend_write", M_FIX, 1, 100);
        cpu_busy = 1'b1;
        #1;
        checkOutput("contend_write_active", 32'(scrub_active), 32'd0);
        checkOutput("contend_write_we", 32'(mem_we), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("contend_write_to_req", 32'(m_ph), 32'(M_ASK));
        waitPass("contend_pass", 200);
        checkOutput("contend_write_once", 32'(write_cnt[1]), 32'd1);
        checkOutput("contend_total_writes", 32'(total_writes), 32'd1);
        checkOutput("contend_w_data", 32'(last_w_data), 32'h12345);
        checkOutput("contend_err_count", 32'(err_count), 32'd2);

        // Saturation: every word in error for two passes.
        $display("[TB] saturation");
        clearLogs();
        for (int i = 0; i < DEPTH; i++) bad[i] = 1'b1;
        waitPass("sat_pass1", 200);
        checkOutput("sat_writes1", 32'(total_writes), 32'd4);
        checkOutput("sat_count1", 32'(err_count), 32'd3);
        for (int i = 0; i < DEPTH; i++) bad[i] = 1'b1;
        waitPass("sat_pass2", 200);
        checkOutput("sat_writes2", 32'(total_writes), 32'd8);
        checkOutput("sat_count2", 32'(err_count), 32'd3);

        // Enable dropped while stalled in REQ.
        $display("[TB] enable drop");
        cpu_busy = 1'b1;
        waitModel("drop_req", M_ASK, -1, 100);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("drop_model_idle", 32'(m_ph), 32'(M_WAIT));
        checkOutput("drop_model_tmr", 32'(m_tmr), 32'd0);
        checkOutput("drop_active", 32'(scrub_active), 32'd0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (!scrub_active && n < 50) begin
            @(posedge clk);
            #3;
            n++;
        end
        checkOutput("restart_latency", 32'(n), 32'd5);

        // Reset asserted in the middle of a writeback.
        $display("[TB] reset during write");
        for (int i = 0; i < DEPTH; i++) bad[i] = 1'b1;
        waitModel("rst_write", M_FIX, -1, 100);
        #1;
        checkOutput("rst_pre_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_we_now", 32'(mem_we), 32'd0);
        checkOutput("rst_active_now", 32'(scrub_active), 32'd0);
        checkOutput("rst_addr_now", 32'(mem_addr), 32'd0);
        checkOutput("rst_count_now", 32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("post_rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("post_rst_count", 32'(err_count), 32'd0);
        checkOutput("post_rst_pass", 32'(pass_done), 32'd0);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_scrubber.md
Name: ecc_scrubber

Overview:
- Background scrub controller for an array of 20-bit ECC memory words.
- Walks the array one word at a time and reads each word plus its error flag.
- Writes the voted, corrected value back to any word that flags an error, which restores the redundant copies.
- Sits beside the CPU memory port; the CPU always has priority and the scrubber only uses idle cycles.

Parameters:
- DATA_W, 20, memory word width.
- ADDR_W, 8, address width.
- DEPTH, 256, number of words scrubbed; the address wraps at DEPTH-1.
- INTERVAL, 1024, cycles between starting successive word scrubs (minimum 4).
- CNT_W, 16, width of the corrected-error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scrubbing enabled.
- cpu_busy  in  1  CPU owns the memory port this cycle.
- mem_rdata  in  DATA_W  voted word at mem_addr; combinational from the array.
- mem_err  in  1  any bit of the addressed word disagrees among its copies.
- scrub_active  out  1  scrubber owns the memory port this cycle; the top-level mux selects the scrubber's address and write enable.
- mem_addr  out  ADDR_W  scrub address (current address pointer).
- mem_we  out  1  write enable for the scrub writeback.
- mem_wdata  out  DATA_W  corrected data for the writeback.
- err_count  out  CNT_W  saturating count of corrected words.
- pass_done  out  1  one-cycle pulse when the address wraps DEPTH-1 -> 0.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; address pointer=0; interval counter=0; capture register=0.
  - err_count=0; pass_done=0; scrub_active=0; mem_we=0.
- Interval counter:
  - While enable=1 it increments every cycle, saturating at INTERVAL-1.
  - It clears on leaving IDLE.
  - While enable=0 it holds at 0.
- States:
  - IDLE: go to REQ when enable=1 and the interval counter is at INTERVAL-1.
  - REQ: wait for cpu_busy=0, then go to READ. If enable=0, return to IDLE.
  - READ:
    - scrub_active=!cpu_busy; mem_we=0.
    - If cpu_busy=1, go back to REQ without sampling.
    - Otherwise capture mem_rdata. If mem_err=1 go to WRITE, else go to NEXT.
    - enable dropping here still lets the read complete.
  - WRITE:
    - scrub_active=!cpu_busy; mem_we=!cpu_busy; mem_wdata=captured word.
    - If cpu_busy=1, return to REQ; the word is re-read next time, because the CPU may have written it.
    - On success, err_count increments, saturating at all-ones, then go to NEXT.
    - enable=0 does not abort WRITE.
  - NEXT:
    - Address pointer increments; DEPTH-1 wraps to 0.
    - pass_done=1 for exactly this cycle on wrap.
    - Go to IDLE.
- Output decoding:
  - scrub_active and mem_we are combinational from state and cpu_busy. They are never 1 while cpu_busy=1.
  - mem_addr always equals the address pointer.
- Minimum latency, no contention, clean word: REQ -> READ -> NEXT, 3 cycles after the interval expires. A word with an error takes 4 cycles.
- Simultaneous events:
  - cpu_busy takes priority over every scrubber action.
  - mem_err is ignored in any state except READ.
- Reset mid-WRITE forces mem_we=0 immediately, because reset is asynchronous.

Optional Feature:
- Macro: SCRUB_ERR_LOG_EN.
- When defined:
  - Adds output last_err_addr [ADDR_W-1:0], reset 0, loaded with the address on every successful WRITE.
  - Adds output err_sticky [1], reset 0, set by a successful WRITE and cleared only by reset.
- When undefined: neither port nor their registers exist. All other behaviour is identical.

Test Plan:
- Clean pass: DEPTH=4, INTERVAL=4, enable=1, no errors, cpu_busy=0.
  - Expect reads at addresses 0,1,2,3 with mem_we never 1.
  - Expect pass_done to pulse once after address 3; err_count=0.
- Single correction: mem_err=1 and mem_rdata=0x5A5A5 at address 2.
  - Expect mem_we=1 with mem_addr=2 and mem_wdata=0x5A5A5 the cycle after READ.
  - Expect err_count=1 (and, with SCRUB_ERR_LOG_EN, last_err_addr=2).
- CPU contention: cpu_busy=1 during READ and during WRITE.
  - Expect scrub_active=0 and mem_we=0 in those cycles.
  - Expect a return to REQ at the same address; the eventual writeback happens exactly once.
- Saturation: CNT_W=2 with errors forced on every word.
  - Expect err_count to reach 3 and stay at 3.
- Enable and reset: drop enable in REQ, expect IDLE with the interval counter at 0.
  - Assert rst during WRITE and expect mem_we=0 immediately.
  - After release, expect address=0 and err_count=0.
